top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 24, giving the sample width in bits (signed two's complement).
REQ-002 The module SHALL have parameter FIR_DEPTH, default 256, giving the number of filter taps; it must be a power of two and at least 2.
REQ-003 i_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  global enable; low SHALL freeze all state.
REQ-006 i_din  input  1  serial input sample bit, LSB first.
REQ-007 i_din_valid  input  1  i_din carries a valid bit this cycle.
REQ-008 i_ready  input  1  downstream can accept an output bit this cycle.
REQ-009 o_ready  output  1  module can accept an input bit this cycle.
REQ-010 o_dout  output  1  serial filtered output bit, LSB first.
REQ-011 o_dout_valid  output  1  o_dout is valid and transfers this cycle.

Function
REQ-012 An input bit SHALL be accepted on a rising edge where i_en=1, i_din_valid=1 and o_ready=1; bit k of a word is the k-th accepted bit (k=0 is the LSB).
REQ-013 When i_din_valid drops mid-word, the partially received bits SHALL be retained, and reception SHALL resume at the next accepted bit.
REQ-014 On the edge that accepts bit DATA_WIDTH-1 (edge E), the word SHALL be complete, and o_ready SHALL go low from E.
REQ-015 o_ready SHALL stay low until the edge that transfers the last output bit, and SHALL be high after that edge.
REQ-016 The filter SHALL be a moving average: y = (sum of the last FIR_DEPTH input words) >>> log2(FIR_DEPTH).
  - The shift is arithmetic, i.e. floor division.
  - The result fits in DATA_WIDTH bits.
REQ-017 The sum SHALL be kept as a running accumulator of width DATA_WIDTH+log2(FIR_DEPTH): acc = acc + x_new - x_oldest.
REQ-018 History SHALL be a FIR_DEPTH-entry circular buffer with a write pointer that wraps from FIR_DEPTH-1 to 0; it may be implemented as RAM.
REQ-019 A fill counter SHALL track words received since reset, saturating at FIR_DEPTH.
  - While fill < FIR_DEPTH, x_oldest SHALL be treated as 0, so unwritten entries count as zero.
REQ-020 Pipeline timing:
  - E+1: read x_oldest.
  - E+2: update acc, pointer and fill.
  - E+3: load y into the output shift register.
  - o_dout_valid SHALL first be high after edge E+3, while i_ready=1.
REQ-021 o_dout_valid SHALL equal (serializer busy AND i_ready AND i_en).
  - o_dout SHALL present the current bit.
  - The bit index SHALL advance only on edges where o_dout_valid=1.
REQ-022 While i_ready=0, o_dout_valid SHALL be 0 and the pending bit SHALL be held; after DATA_WIDTH transferred bits the serializer SHALL return idle.
REQ-023 When i_en=0, no bit SHALL be accepted, the pipeline and serializer SHALL hold, o_dout_valid SHALL be 0, and o_ready SHALL keep its value.
REQ-024 An input word SHALL NOT be accepted while the previous word is in the pipeline or serializer; no overflow path exists.

Reset
REQ-025 While i_rst=0, the following SHALL be cleared immediately, regardless of i_clk:
  - bit counter, partial word, acc, write pointer, fill counter and serializer state SHALL be 0;
  - o_ready SHALL be 1, o_dout SHALL be 0, o_dout_valid SHALL be 0.
REQ-026 History buffer contents need not be cleared, since the fill counter masks them (REQ-019).
REQ-027 Reset asserted mid-word or mid-output SHALL abort the operation, and the first word after release SHALL start at bit 0.

Verification
REQ-028 After reset, send 0x000100 (DATA_WIDTH=24, FIR_DEPTH=256) with i_ready=1 -> output word 0x000001, with o_dout_valid high for 24 consecutive cycles starting after edge E+3.
REQ-029 Send impulse 0x000100, then 0x000000 repeatedly -> outputs 0x000001 for words 1..256, then 0x000000 from word 257 (wrap-around and oldest subtraction).
REQ-030 Send 0x7FFFFF 256 times -> word k outputs floor(k*0x7FFFFF/256); word 256 outputs 0x7FFFFF, with no overflow.
REQ-031 Send single words 0xFFFF00 and 0xFFFFFF (each after reset) -> outputs 0xFFFFFF and 0xFFFFFF (arithmetic floor).
REQ-032 Hold i_ready=0 for 10 cycles mid-output -> o_dout_valid=0, bit held, o_ready stays 0; the word completes correctly after release.
REQ-033 Toggle i_din_valid and i_en low mid-word, and separately pulse i_rst low mid-word -> the first two yield a correct resumed word; reset yields all outputs at reset values and a clean next word.

Source files
------------

// File: rtl/top_level.sv
// Bit-serial moving-average filter.
// Samples arrive LSB first, are averaged over the last FIR_DEPTH words using a
// running accumulator and a circular history buffer, and leave LSB first
// through a serializer that honours downstream back-pressure.
module top_level #(
   parameter int DATA_WIDTH = 24,
   parameter int FIR_DEPTH  = 256
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_din,
   input  logic i_din_valid,
   input  logic i_ready,
   output logic o_ready,
   output logic o_dout,
   output logic o_dout_valid
);

   localparam int LOG2  = $clog2(FIR_DEPTH);
   localparam int ACC_W = DATA_WIDTH + LOG2;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [LOG2:0]    FILL_FULL = (LOG2 + 1)'(FIR_DEPTH);

   // Word lifecycle: receive, read oldest, accumulate, load output, send
   localparam logic [2:0] S_RX   = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_ACC  = 3'd2;
   localparam logic [2:0] S_LOAD = 3'd3;
   localparam logic [2:0] S_SEND = 3'd4;

   logic [2:0]            state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      out_cnt;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] oldest;
   logic [DATA_WIDTH-1:0] hist_rd;
   logic [DATA_WIDTH-1:0] sreg;
   logic [ACC_W-1:0]      acc;
   logic [LOG2-1:0]       wr_ptr;
   logic [LOG2:0]         fill;

   logic [DATA_WIDTH-1:0] hist [FIR_DEPTH];

   assign hist_rd      = hist[wr_ptr];
   assign o_ready      = (state == S_RX);
   assign o_dout       = sreg[0];
   assign o_dout_valid = (state == S_SEND) && i_ready && i_en;

   // History buffer: the new word overwrites the oldest slot while it is read
   always_ff @(posedge i_clk) begin
      if (i_en && state == S_READ) begin
         hist[wr_ptr] <= rx_word;
      end
   end

   // Receive, filter pipeline and serializer sequencing
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= S_RX;
         bit_cnt <= '0;
         out_cnt <= '0;
         rx_word <= '0;
         oldest  <= '0;
         sreg    <= '0;
         acc     <= '0;
         wr_ptr  <= '0;
         fill    <= '0;
      end else if (i_en) begin
         case (state)
            S_RX: begin
               if (i_din_valid) begin
                  rx_word <= {i_din, rx_word[DATA_WIDTH-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= S_READ;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            S_READ: begin
               // Slots never written since reset contribute zero
               oldest <= (fill == FILL_FULL) ? hist_rd : '0;
               state  <= S_ACC;
            end
            S_ACC: begin
               acc    <= acc + {{LOG2{rx_word[DATA_WIDTH-1]}}, rx_word}
                             - {{LOG2{oldest[DATA_WIDTH-1]}}, oldest};
               wr_ptr <= wr_ptr + LOG2'(1);
               if (fill != FILL_FULL) begin
                  fill <= fill + (LOG2 + 1)'(1);
               end
               state  <= S_LOAD;
            end
            S_LOAD: begin
               // Taking the top DATA_WIDTH bits is the arithmetic shift by LOG2
               sreg    <= acc[ACC_W-1 -: DATA_WIDTH];
               out_cnt <= '0;
               state   <= S_SEND;
            end
            S_SEND: begin
               if (i_ready) begin
                  sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
                  if (out_cnt == LAST_BIT) begin
                     out_cnt <= '0;
                     state   <= S_RX;
                  end else begin
                     out_cnt <= out_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= S_RX;
         endcase
      end
   end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for the bit-serial moving-average filter (24-bit, 256 taps).
module tb_top_level;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic din;
   logic din_valid;
   logic rdy;
   logic ready;
   logic dout;
   logic dout_valid;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [23:0] y;
   logic [63:0] e64;
   int          lat;
   int          gaps;
   int          t;

   top_level #(
      .DATA_WIDTH(24),
      .FIR_DEPTH (256)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_din       (din),
      .i_din_valid (din_valid),
      .i_ready     (rdy),
      .o_ready     (ready),
      .o_dout      (dout),
      .o_dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      din_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // gap_kind 1: din_valid low for 3 cycles before bit gap_at; 2: en low instead
   task automatic send_word(input logic [23:0] w, input int gap_at, input int gap_kind);
      int tw;
      tw = 0;
      while (!ready && tw < 500) begin
         tick();
         tw++;
      end
      if (!ready) chk("send_ready_timeout", 32'(ready), 32'd1);
      for (int k = 0; k < 24; k++) begin
         if (k == gap_at) begin
            din = ~w[k];
            if (gap_kind == 1) begin
               din_valid = 1'b0;
            end else begin
               din_valid = 1'b1;
               en = 1'b0;
            end
            repeat (3) tick();
            if (gap_kind == 2) chk("en_low_ready_held", 32'(ready), 32'd1);
         end
         din = w[k];
         din_valid = 1'b1;
         en = 1'b1;
         tick();
      end
      din_valid = 1'b0;
      din = 1'b0;
   endtask

   // stall_kind 1: ready low for 10 cycles at bit stall_at; 2: en low instead
   task automatic recv(input logic [23:0] exp, input int stall_at, input int stall_kind,
                       output logic [23:0] yo, output int lo, output int go);
      int  got;
      int  tr;
      bit  stalled;
      yo = '0;
      lo = 0;
      go = 0;
      got = 0;
      tr = 0;
      stalled = 1'b0;
      while (!dout_valid && lo < 200) begin
         tick();
         lo++;
      end
      while (got < 24 && tr < 400) begin
         if (got == stall_at && !stalled) begin
            stalled = 1'b1;
            if (stall_kind == 1) rdy = 1'b0;
            else en = 1'b0;
            #1;
            for (int s = 0; s < 10; s++) begin
               chk("stall_valid_low", 32'(dout_valid), 32'd0);
               chk("stall_bit_held", 32'(dout), 32'(exp[got]));
               chk("stall_ready_low", 32'(ready), 32'd0);
               tick();
            end
            rdy = 1'b1;
            en = 1'b1;
            #1;
         end
         if (dout_valid) begin
            yo[got] = dout;
            got++;
         end else begin
            go++;
         end
         tick();
         tr++;
      end
      if (got < 24) chk("recv_timeout", 32'(got), 32'd24);
   endtask

   initial begin
      rst = 1'b0;
      en = 1'b1;
      rdy = 1'b1;
      din = 1'b0;
      din_valid = 1'b0;
      repeat (3) tick();
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_valid", 32'(dout_valid), 32'd0);
      rst = 1'b1;
      tick();

      // First word after reset: latency and contiguous output
      send_word(24'h000100, -1, 0);
      chk("ready_low_after_E", 32'(ready), 32'd0);
      recv(24'h000001, -1, 0, y, lat, gaps);
      chk("first_word", 32'(y), 32'h000001);
      chk("first_latency", 32'(lat), 32'd3);
      chk("first_gaps", 32'(gaps), 32'd0);
      chk("ready_high_after_last", 32'(ready), 32'd1);
      chk("valid_low_after_last", 32'(dout_valid), 32'd0);

      // Impulse response continues for 256 words, then the oldest is subtracted
      for (int k = 2; k <= 258; k++) begin
         send_word(24'h000000, -1, 0);
         recv(24'h000000, -1, 0, y, lat, gaps);
         chk("impulse_word", 32'(y), (k <= 256) ? 32'h000001 : 32'h000000);
      end

      // Ramp to full-scale positive without overflow
      do_reset();
      for (int k = 1; k <= 256; k++) begin
         send_word(24'h7FFFFF, -1, 0);
         recv(24'h000000, -1, 0, y, lat, gaps);
         e64 = (64'(k) * 64'h7FFFFF) >> 8;
         chk("ramp_word", 32'(y), 32'(e64[23:0]));
      end
      chk("ramp_final", 32'(y), 32'h7FFFFF);

      // Negative inputs floor toward minus infinity
      do_reset();
      send_word(24'hFFFF00, -1, 0);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("neg_ffff00", 32'(y), 32'hFFFFFF);
      do_reset();
      send_word(24'hFFFFFF, -1, 0);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("neg_ffffff", 32'(y), 32'hFFFFFF);

      // Back-pressure mid-output
      do_reset();
      send_word(24'hABCD00, -1, 0);
      recv(24'hFFABCD, 5, 1, y, lat, gaps);
      chk("stall_ready_word", 32'(y), 32'hFFABCD);
      chk("stall_ready_gaps", 32'(gaps), 32'd0);
      chk("stall_ready_after", 32'(ready), 32'd1);

      // Enable low mid-output
      do_reset();
      send_word(24'h003400, -1, 0);
      recv(24'h000034, 12, 2, y, lat, gaps);
      chk("stall_en_word", 32'(y), 32'h000034);

      // Input gaps mid-word
      do_reset();
      send_word(24'h123456, 7, 1);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("din_valid_gap_word", 32'(y), 32'h001234);
      do_reset();
      send_word(24'h654321, 15, 2);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("en_gap_word", 32'(y), 32'h006543);

      // Reset mid-word after a completed word
      do_reset();
      send_word(24'h7FFF00, -1, 0);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("pre_reset_word", 32'(y), 32'h007FFF);
      for (int k = 0; k < 10; k++) begin
         din = 1'b1;
         din_valid = 1'b1;
         tick();
      end
      rst = 1'b0;
      din_valid = 1'b0;
      #2;
      chk("midword_rst_ready", 32'(ready), 32'd1);
      chk("midword_rst_dout", 32'(dout), 32'd0);
      chk("midword_rst_valid", 32'(dout_valid), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      send_word(24'h000200, -1, 0);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("after_midword_rst", 32'(y), 32'h000002);

      // Reset mid-output
      send_word(24'h7FFF00, -1, 0);
      t = 0;
      while (!dout_valid && t < 50) begin
         tick();
         t++;
      end
      repeat (5) tick();
      rst = 1'b0;
      #2;
      chk("midout_rst_ready", 32'(ready), 32'd1);
      chk("midout_rst_dout", 32'(dout), 32'd0);
      chk("midout_rst_valid", 32'(dout_valid), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      send_word(24'h000300, -1, 0);
      recv(24'h000000, -1, 0, y, lat, gaps);
      chk("after_midout_rst", 32'(y), 32'h000003);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
